alu_share_arbiter: RTL and testbench

- Two-lane round-robin arbiter and 2-stage pipeline that shares one ALU between the two issue lanes of the superscalar core.
- Accepts operand/opcode requests per lane over valid/ready, registers the winner into an operand stage that drives the external ALU, and captures ALU Result/Zero into a result stage with lane/tag for writeback.
- Supports flush and backpressure, and flags opcodes the ALU does not define.

---
 rtl/alu_share_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-lane round-robin arbiter plus operand/result pipeline for a shared ALU.
// Ports: clk, reset, flush, req0_*/req1_* issue lanes, alu_* ALU link, res_* writeback.
module alu_share_arbiter #(
  parameter int XLEN  = 32,
  parameter int CTRLW = 4,
  parameter int TAGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [XLEN-1:0]  req0_a,
  input  logic [XLEN-1:0]  req0_b,
  input  logic [CTRLW-1:0] req0_ctrl,
  input  logic [TAGW-1:0]  req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [XLEN-1:0]  req1_a,
  input  logic [XLEN-1:0]  req1_b,
  input  logic [CTRLW-1:0] req1_ctrl,
  input  logic [TAGW-1:0]  req1_tag,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [CTRLW-1:0] alu_ctrl,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [XLEN-1:0]  res_data,
  output logic             res_zero,
  output logic             res_lane,
  output logic [TAGW-1:0]  res_tag,
  output logic             res_illegal
);

  typedef struct packed {
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [CTRLW-1:0] ctrl;
    logic [TAGW-1:0]  tag;
    logic             lane;
  } op_t;

  logic s1_valid;
  op_t  s1;
  op_t  sel;
  logic rr_last;
  logic s2_take;
  logic s1_take;
  logic hs0;
  logic hs1;
  logic hs;
  logic illegal;

  assign s2_take = !res_valid || res_ready;
  assign s1_take = !s1_valid || s2_take;

  // Each ready masks only the other lane's claim, so the
  // two handshakes are mutually exclusive by construction.
  assign req0_ready = s1_take && !flush
                   && !(req1_valid && !rr_last);
  assign req1_ready = s1_take && !flush
                   && !(req0_valid && rr_last);

  assign hs0 = req0_valid && req0_ready;
  assign hs1 = req1_valid && req1_ready;
  assign hs  = hs0 || hs1;

  always_comb begin
    sel = '0;
    unique case (1'b1)
      hs1: begin
        sel.a    = req1_a;
        sel.b    = req1_b;
        sel.ctrl = req1_ctrl;
        sel.tag  = req1_tag;
        sel.lane = 1'b1;
      end
      default: begin
        sel.a    = req0_a;
        sel.b    = req0_b;
        sel.ctrl = req0_ctrl;
        sel.tag  = req0_tag;
        sel.lane = 1'b0;
      end
    endcase
  end

  assign alu_a    = s1.a;
  assign alu_b    = s1.b;
  assign alu_ctrl = s1.ctrl;
  assign illegal  = s1.ctrl > CTRLW'(12);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last <= 1'b1;
    end else if (hs) begin
      rr_last <= hs1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_take) begin
      s1_valid <= hs;
      if (hs) begin
        s1 <= sel;
      end
    end
  end

  // Undefined opcodes leave the ALU output undefined, so the
  // result is forced to a clean zero instead of trusting it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_zero    <= 1'b0;
      res_lane    <= 1'b0;
      res_tag     <= '0;
      res_illegal <= 1'b0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (s2_take) begin
      res_valid   <= s1_valid;
      res_illegal <= illegal;
      if (s1_valid) begin
        res_data <= illegal ? '0 : alu_result;
        res_zero <= illegal ? 1'b1 : alu_zero;
        res_lane <= s1.lane;
        res_tag  <= s1.tag;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with an ALU model.
// Directed scenarios followed by randomized traffic.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [3:0]  req0_ctrl;
  logic [4:0]  req0_tag;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [3:0]  req1_ctrl;
  logic [4:0]  req1_tag;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_zero;
  logic        res_lane;
  logic [4:0]  res_tag;
  logic        res_illegal;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl), .req1_tag(req1_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero),
    .res_lane(res_lane), .res_tag(res_tag),
    .res_illegal(res_illegal)
  );

  function automatic logic [31:0] ref_alu(
    input logic [31:0] a, input logic [31:0] b,
    input logic [3:0] c);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return {31'b0, $signed(a) < $signed(b)};
      4'd6:    return {31'b0, a < b};
      4'd7:    return a << b[4:0];
      4'd8:    return a >> b[4:0];
      4'd9:    return $signed(a) >>> b[4:0];
      4'd10:   return ~(a | b);
      4'd11:   return b;
      4'd12:   return a & ~b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // External ALU: garbage on undefined opcodes.
  assign alu_result = ref_alu(alu_a, alu_b, alu_ctrl);
  assign alu_zero = (alu_ctrl > 4'd12) ? 1'b0 : (alu_result == 0);

  typedef struct {
    logic [31:0] d;
    logic        z;
    logic        lane;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int n_out = 0;
  logic m_last = 1'b1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue-side observer: predicts each accepted request.
  always @(negedge clk) begin
    logic h0, h1;
    exp_t e;
    if (reset) begin
      m_last = 1'b1;
    end else begin
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      if (h0 && h1) chk("one_handshake", 2, 1);
      if (flush) begin
        chk("flush_ready0", req0_ready, 0);
        chk("flush_ready1", req1_ready, 0);
      end
      if (h0 || h1) begin
        if (req0_valid && req1_valid)
          chk("rr_alternate", h1, !m_last);
        m_last = h1;
        e.lane = h1;
        e.tag  = h1 ? req1_tag : req0_tag;
        if ((h1 ? req1_ctrl : req0_ctrl) > 4'd12) begin
          e.ill = 1'b1;
          e.d   = 0;
          e.z   = 1'b1;
        end else begin
          e.ill = 1'b0;
          e.d   = h1 ? ref_alu(req1_a, req1_b, req1_ctrl)
                     : ref_alu(req0_a, req0_b, req0_ctrl);
          e.z   = (e.d == 0);
        end
        q.push_back(e);
      end
    end
  end

  // Result-side monitor: pops and compares, checks hold.
  logic        hold = 1'b0;
  logic [31:0] h_d;
  logic        h_z, h_l, h_i;
  logic [4:0]  h_t;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", res_valid, 1);
        chk("hold_data", res_data, h_d);
        chk("hold_meta", {res_z_l_t_i()},
            {h_z, h_l, h_t, h_i});
      end
      if (res_valid && res_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0h expected none",
                   res_data);
        end else begin
          e = q.pop_front();
          n_out++;
          chk("res_data", res_data, e.d);
          chk("res_zero", res_zero, e.z);
          chk("res_lane", res_lane, e.lane);
          chk("res_tag", res_tag, e.tag);
          chk("res_illegal", res_illegal, e.ill);
        end
      end
      if (flush) q.delete();
      hold = res_valid && !res_ready && !flush;
      h_d = res_data;
      h_z = res_zero;
      h_l = res_lane;
      h_t = res_tag;
      h_i = res_illegal;
    end
  end

  function automatic logic [7:0] res_z_l_t_i();
    return {res_zero, res_lane, res_tag, res_illegal};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int base;
    logic r;
    reset = 1'b1;
    flush = 1'b0;
    res_ready = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0;
    req0_ctrl = 0; req0_tag = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0;
    req1_ctrl = 0; req1_tag = 0;
    repeat (2) step();
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_meta", res_z_l_t_i(), 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    reset = 1'b0;

    // single op
    req0_a = 5; req0_b = 3; req0_ctrl = 1; req0_tag = 7;
    req0_valid = 1;
    #1 chk("t1_ready", req0_ready, 1);
    step();
    req0_valid = 0;
    chk("t1_alu_a", alu_a, 5);
    chk("t1_alu_ctrl", alu_ctrl, 1);
    chk("t1_latency", res_valid, 0);
    step();
    chk("t1_valid", res_valid, 1);
    chk("t1_data", res_data, 2);
    chk("t1_meta", res_z_l_t_i(), {1'b0, 1'b0, 5'd7, 1'b0});

    // round-robin from a fresh reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    req0_a = 1; req0_b = 1; req0_ctrl = 0; req0_tag = 1;
    req1_a = 6; req1_b = 6; req1_ctrl = 4; req1_tag = 2;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t2_grant", {req1_ready, req0_ready},
             (i % 2) ? 2 : 1);
      step();
    end
    #1 chk("t2_rr_end", {req1_ready, req0_ready}, 1);
    req0_valid = 0; req1_valid = 0;
    repeat (3) step();

    // backpressure
    res_ready = 0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      req0_a = acc + 10; req0_b = 0; req0_ctrl = 0;
      req0_tag = 5'(acc); req0_valid = 1;
      #1 r = req0_ready;
      step();
      if (r) acc++;
    end
    chk("t3_accepts", acc, 2);
    chk("t3_valid", res_valid, 1);
    chk("t3_data", res_data, 10);
    chk("t3_ready_low", req0_ready, 0);
    base = n_out;
    res_ready = 1;
    for (int k = 0; k < 20 && acc < 4; k++) begin
      req0_a = acc + 10; req0_tag = 5'(acc);
      req0_valid = 1;
      #1 r = req0_ready;
      step();
      if (r) acc++;
    end
    req0_valid = 0;
    chk("t3_all_accepted", acc, 4);
    repeat (4) step();
    chk("t3_drained", n_out - base, 4);

    // illegal opcode
    req1_a = $urandom; req1_b = $urandom;
    req1_ctrl = 4'b1110; req1_tag = 9; req1_valid = 1;
    #1 chk("t4_ready", req1_ready, 1);
    step();
    req1_valid = 0;
    step();
    chk("t4_valid", res_valid, 1);
    chk("t4_data", res_data, 0);
    chk("t4_meta", res_z_l_t_i(), {1'b1, 1'b1, 5'd9, 1'b1});
    step();

    // flush
    res_ready = 0;
    req0_ctrl = 0; req0_b = 0;
    req0_a = 20; req0_tag = 20; req0_valid = 1;
    step();
    req0_a = 21; req0_tag = 21;
    step();
    req0_a = 22; req0_tag = 22; flush = 1;
    #1 chk("t5_flush_ready", req0_ready, 0);
    step();
    flush = 0;
    chk("t5_res_flushed", res_valid, 0);
    #1 chk("t5_refill_ready", req0_ready, 1);
    step();
    req0_valid = 0;
    chk("t5_s1_only", res_valid, 0);
    step();
    chk("t5_valid", res_valid, 1);
    chk("t5_data", res_data, 22);
    res_ready = 1;
    step();

    // asynchronous reset mid-stream
    req0_b = 1; req0_ctrl = 0; req0_valid = 1;
    for (int k = 0; k < 3; k++) begin
      req0_a = 30 + k; req0_tag = 5'(k);
      step();
    end
    #2 reset = 1'b1;
    #1 chk("t6_async_clear", res_valid, 0);
    req0_valid = 0;
    step();
    reset = 1'b0;
    req0_a = 1; req0_b = 2; req1_a = 3; req1_b = 4;
    req1_ctrl = 0;
    req0_valid = 1; req1_valid = 1;
    #1 chk("t6_first_tie", {req1_ready, req0_ready}, 1);
    step();
    req0_valid = 0; req1_valid = 0;
    repeat (3) step();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = $urandom_range(0, 1) ? $urandom
                                    : $urandom_range(0, 3);
      req0_b = $urandom_range(0, 3);
      req1_a = $urandom;
      req1_b = $urandom_range(0, 1) ? req1_a : $urandom;
      req0_ctrl = 4'($urandom_range(0, 15));
      req1_ctrl = 4'($urandom_range(0, 15));
      req0_tag = 5'($urandom);
      req1_tag = 5'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      step();
    end
    flush = 0; req0_valid = 0; req1_valid = 0;
    res_ready = 1;
    for (int k = 0; k < 20 && q.size() != 0; k++) step();
    step();
    chk("drain_empty", q.size(), 0);
    chk("drain_valid", res_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
